// File: rtl/sensor_sched_pkg.sv
// Shared types and constants for the sensor poll scheduler: FSM states,
// sensor selection, host command bytes and frame tag bytes.
package sensor_sched_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      WAIT,
      TX_TAG,
      TX_HI,
      TX_LO
   } state_t;

   typedef enum logic {
      SEL_DHT,
      SEL_HC
   } sel_t;

   localparam logic [7:0] CMD_T    = 8'h54;
   localparam logic [7:0] CMD_D    = 8'h44;
   localparam logic [7:0] CMD_AUTO = 8'h41;
   localparam logic [7:0] CMD_STOP = 8'h53;

   localparam logic [7:0] TAG_T   = 8'h54;
   localparam logic [7:0] TAG_D   = 8'h44;
   localparam logic [7:0] TAG_ERR = 8'h45;

   function automatic logic [7:0] sensor_tag(input sel_t sel);
      return (sel == SEL_DHT) ? TAG_T : TAG_D;
   endfunction

endpackage

// File: rtl/sensor_poll_scheduler_period_timer.sv
// Wrap counter 0..PERIOD-1 with enable and synchronous clear; tick is high
// for the one cycle in which the enabled counter sits on its last value.
module period_timer #(
   parameter int unsigned PERIOD = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
   localparam logic [W-1:0] LAST = W'(PERIOD - 1);

   logic [W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

   assign tick = en && (count == LAST);

endmodule

// File: rtl/sensor_poll_scheduler.sv
// Sequences DHT11 and HC-SR04 measurements from host commands or auto-poll,
// waits for each result with a timeout, and sends it as a 3-byte UART frame.
module sensor_poll_scheduler
   import sensor_sched_pkg::*;
#(
   parameter int unsigned PERIOD_CYCLES  = 100_000_000,
   parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cmd_valid,
   input  logic [7:0]  cmd_byte,
   output logic [7:0]  uart_tx,
   output logic        uart_tx_valid,
   input  logic        uart_ready,
   output logic        dht11_start,
   input  logic [15:0] dht11_data,
   input  logic        dht11_data_available,
   output logic        hc_sr04_start,
   input  logic [15:0] hc_sr04_data,
   input  logic        hc_sr04_data_available,
   output logic        busy,
   output logic        auto_active
);

   localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [TW-1:0] TIMEOUT_LOAD = TW'(TIMEOUT_CYCLES - 1);

   state_t        state;
   sel_t          sel;
   sel_t          last_served;
   logic          pend_t;
   logic          pend_d;
   logic [TW-1:0] timer;
   logic          dht_avail_q;
   logic          hc_avail_q;
   logic [7:0]    byte_hi;
   logic [7:0]    byte_lo;

   logic cmd_t, cmd_d, cmd_auto, cmd_stop;
   logic tick;
   logic dht_rise, hc_rise, sel_rise;

   assign cmd_t    = cmd_valid && (cmd_byte == CMD_T);
   assign cmd_d    = cmd_valid && (cmd_byte == CMD_D);
   assign cmd_auto = cmd_valid && (cmd_byte == CMD_AUTO);
   assign cmd_stop = cmd_valid && (cmd_byte == CMD_STOP);

   assign dht_rise = dht11_data_available && !dht_avail_q;
   assign hc_rise  = hc_sr04_data_available && !hc_avail_q;
   assign sel_rise = (sel == SEL_DHT) ? dht_rise : hc_rise;

   assign busy = (state != IDLE);

   period_timer #(
      .PERIOD(PERIOD_CYCLES)
   ) u_period_timer (
      .clk (clk),
      .rst (rst),
      .en  (auto_active),
      .clr (cmd_auto || cmd_stop),
      .tick(tick)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         sel           <= SEL_DHT;
         last_served   <= SEL_HC;
         pend_t        <= 1'b0;
         pend_d        <= 1'b0;
         timer         <= '0;
         dht_avail_q   <= 1'b0;
         hc_avail_q    <= 1'b0;
         byte_hi       <= '0;
         byte_lo       <= '0;
         uart_tx       <= '0;
         uart_tx_valid <= 1'b0;
         dht11_start   <= 1'b0;
         hc_sr04_start <= 1'b0;
         auto_active   <= 1'b0;
      end else begin
         dht_avail_q   <= dht11_data_available;
         hc_avail_q    <= hc_sr04_data_available;
         dht11_start   <= 1'b0;
         hc_sr04_start <= 1'b0;

         if (cmd_auto) begin
            auto_active <= 1'b1;
         end else if (cmd_stop) begin
            auto_active <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (pend_t || pend_d) begin
                  // Round-robin: on a tie, serve the sensor not served last.
                  if (pend_t && (!pend_d || last_served == SEL_HC)) begin
                     sel         <= SEL_DHT;
                     last_served <= SEL_DHT;
                     pend_t      <= 1'b0;
                  end else begin
                     sel         <= SEL_HC;
                     last_served <= SEL_HC;
                     pend_d      <= 1'b0;
                  end
                  state <= START;
               end
            end
            START: begin
               dht11_start   <= (sel == SEL_DHT);
               hc_sr04_start <= (sel == SEL_HC);
               timer         <= TIMEOUT_LOAD;
               state         <= WAIT;
            end
            WAIT: begin
               if (sel_rise) begin
                  uart_tx            <= sensor_tag(sel);
                  {byte_hi, byte_lo} <= (sel == SEL_DHT) ? dht11_data : hc_sr04_data;
                  uart_tx_valid      <= 1'b1;
                  state              <= TX_TAG;
               end else if (timer == '0) begin
                  uart_tx       <= TAG_ERR;
                  byte_hi       <= sensor_tag(sel);
                  byte_lo       <= 8'h00;
                  uart_tx_valid <= 1'b1;
                  state         <= TX_TAG;
               end else begin
                  timer <= timer - 1'b1;
               end
            end
            TX_TAG: begin
               if (uart_ready) begin
                  uart_tx <= byte_hi;
                  state   <= TX_HI;
               end
            end
            TX_HI: begin
               if (uart_ready) begin
                  uart_tx <= byte_lo;
                  state   <= TX_LO;
               end
            end
            TX_LO: begin
               if (uart_ready) begin
                  uart_tx       <= '0;
                  uart_tx_valid <= 1'b0;
                  state         <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase

         // NOTE: these sets come after the IDLE clear, so as later non-blocking
         // assignments they win: a request arriving while its own sensor is
         // being selected still causes one more measurement.
         if (cmd_t || tick) begin
            pend_t <= 1'b1;
         end
         if (cmd_d || tick) begin
            pend_d <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Directed-plus-random bench for sensor_poll_scheduler: behavioural sensor
// responders, a byte/start monitor and a transaction-level arbitration model.
module tb_sensor_poll_scheduler;

   localparam int PERIOD  = 200;
   localparam int TIMEOUT = 20;

   localparam logic [7:0] C_T = 8'h54;
   localparam logic [7:0] C_D = 8'h44;
   localparam logic [7:0] C_A = 8'h41;
   localparam logic [7:0] C_S = 8'h53;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic [7:0]  cmd_byte = 8'h00;
   logic        uart_ready = 1'b1;
   logic [7:0]  uart_tx;
   logic        uart_tx_valid;
   logic        dht11_start;
   logic        hc_sr04_start;
   wire  [15:0] dht11_data;
   wire         dht11_data_available;
   wire  [15:0] hc_sr04_data;
   wire         hc_sr04_data_available;
   logic        busy;
   logic        auto_active;

   sensor_poll_scheduler #(
      .PERIOD_CYCLES (PERIOD),
      .TIMEOUT_CYCLES(TIMEOUT)
   ) dut (
      .clk                   (clk),
      .rst                   (rst),
      .cmd_valid             (cmd_valid),
      .cmd_byte              (cmd_byte),
      .uart_tx               (uart_tx),
      .uart_tx_valid         (uart_tx_valid),
      .uart_ready            (uart_ready),
      .dht11_start           (dht11_start),
      .dht11_data            (dht11_data),
      .dht11_data_available  (dht11_data_available),
      .hc_sr04_start         (hc_sr04_start),
      .hc_sr04_data          (hc_sr04_data),
      .hc_sr04_data_available(hc_sr04_data_available),
      .busy                  (busy),
      .auto_active           (auto_active)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      checks++;
      assert (obs === want) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, want);
      end
   endtask

   // ---------------- monitor: accepted bytes, start pulses, hold rule ----------
   logic [7:0] byte_q[$];
   int         byte_cyc[$];
   int         start_sel[$];
   int         start_cyc[$];
   int         proto_err = 0;
   logic       held_pending = 1'b0;
   logic [7:0] held_byte = 8'h00;

   always @(negedge clk) begin
      if (held_pending && !rst && !(uart_tx_valid === 1'b1 && uart_tx === held_byte)) proto_err++;
      held_pending = !rst && uart_tx_valid && !uart_ready;
      held_byte    = uart_tx;
      if (!rst && uart_tx_valid && uart_ready) begin
         byte_q.push_back(uart_tx);
         byte_cyc.push_back(cyc);
      end
      if (dht11_start && hc_sr04_start) proto_err++;
      if (dht11_start) begin
         start_sel.push_back(0);
         start_cyc.push_back(cyc);
      end
      if (hc_sr04_start) begin
         start_sel.push_back(1);
         start_cyc.push_back(cyc);
      end
   end

   // ---------------- sensor responders and expected frames ---------------------
   // resp_delay < 0 means the sensor never answers; fixed_val < 0 means random data.
   int         resp_delay[2];
   int         fixed_val[2];
   int         cnt[2];
   logic [15:0] sdata[2];
   logic        savail[2];
   logic [7:0]  exp_q[$];

   assign dht11_data             = sdata[0];
   assign dht11_data_available   = savail[0];
   assign hc_sr04_data           = sdata[1];
   assign hc_sr04_data_available = savail[1];

   function automatic logic [7:0] tag_of(input int s);
      return (s == 0) ? 8'h54 : 8'h44;
   endfunction

   initial begin
      logic [15:0] v;
      for (int s = 0; s < 2; s++) begin
         sdata[s]  = 16'h0000;
         savail[s] = 1'b0;
         cnt[s]    = 0;
      end
      forever begin
         @(posedge clk);
         #1;
         for (int s = 0; s < 2; s++) begin
            if ((s == 0) ? dht11_start : hc_sr04_start) begin
               savail[s] = 1'b0;
               cnt[s]    = resp_delay[s];
               if (resp_delay[s] < 0) begin
                  exp_q.push_back(8'h45);
                  exp_q.push_back(tag_of(s));
                  exp_q.push_back(8'h00);
               end
            end else if (cnt[s] > 0) begin
               cnt[s]--;
               if (cnt[s] == 0) begin
                  v = (fixed_val[s] >= 0) ? 16'(fixed_val[s]) : 16'($urandom_range(0, 65535));
                  sdata[s]  = v;
                  savail[s] = 1'b1;
                  exp_q.push_back(tag_of(s));
                  exp_q.push_back(v[15:8]);
                  exp_q.push_back(v[7:0]);
               end
            end
         end
      end
   end

   // ---------------- arbitration model (0 = DHT11, 1 = HC-SR04) ----------------
   int mlast = 1;

   function automatic int pick(input bit pt, input bit pd);
      int s;
      if (pt && pd) s = 1 - mlast;
      else          s = pt ? 0 : 1;
      mlast = s;
      return s;
   endfunction

   // ---------------- helpers ----------------------------------------------------
   function automatic logic [31:0] q_byte(input int i);
      if (i < byte_q.size()) return 32'(byte_q[i]);
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] q_bcyc(input int i);
      if (i < byte_cyc.size()) return 32'(byte_cyc[i]);
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] q_sel(input int i);
      if (i < start_sel.size()) return 32'(start_sel[i]);
      return 32'hDEAD_BEEF;
   endfunction

   function automatic logic [31:0] q_scyc(input int i);
      if (i < start_cyc.size()) return 32'(start_cyc[i]);
      return 32'hDEAD_BEEF;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ticks(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send_cmd(input logic [7:0] b, output int c);
      cmd_valid = 1'b1;
      cmd_byte  = b;
      c         = cyc;
      tick();
      cmd_valid = 1'b0;
      cmd_byte  = 8'h00;
   endtask

   task automatic wait_starts(input int n, input int budget, input string tag);
      int k = 0;
      while (start_sel.size() < n && k < budget) begin
         tick();
         k++;
      end
      check({tag, "_starts"}, start_sel.size(), n);
   endtask

   task automatic wait_bytes(input int n, input int budget, input string tag);
      int k = 0;
      while (byte_q.size() < n && k < budget) begin
         tick();
         k++;
      end
      check({tag, "_bytes"}, byte_q.size(), n);
   endtask

   task automatic wait_idle(input int budget, input string tag);
      int k = 0;
      while (busy !== 1'b0 && k < budget) begin
         tick();
         k++;
      end
      check({tag, "_idle"}, busy, 0);
   endtask

   task automatic check_frames(input int b0, input int e0, input string tag);
      int n = exp_q.size() - e0;
      check({tag, "_len"}, byte_q.size() - b0, n);
      for (int i = 0; i < n; i++) begin
         check($sformatf("%s_b%0d", tag, i), q_byte(b0 + i), exp_q[e0 + i]);
      end
   endtask

   // ---------------- directed sequence ------------------------------------------
   initial begin
      int c, c2, s0, b0, e0, d;

      resp_delay[0] = 5;
      resp_delay[1] = 5;
      fixed_val[0]  = -1;
      fixed_val[1]  = -1;

      rst = 1'b1;
      ticks(3);
      check("rst_busy", busy, 0);
      check("rst_valid", uart_tx_valid, 0);
      check("rst_tx", uart_tx, 0);
      check("rst_dht_start", dht11_start, 0);
      check("rst_hc_start", hc_sr04_start, 0);
      check("rst_auto", auto_active, 0);
      rst   = 1'b0;
      mlast = 1;
      tick();

      // 1: 'T' with a fixed reading, UART always ready
      d = $urandom_range(2, 15);
      resp_delay[0] = d;
      fixed_val[0]  = 16'h2573;
      s0 = start_sel.size(); b0 = byte_q.size(); e0 = exp_q.size();
      send_cmd(C_T, c);
      wait_starts(s0 + 1, 20, "t1");
      check("t1_sel", q_sel(s0), pick(1, 0));
      check("t1_start_cyc", q_scyc(s0), c + 3);
      check("t1_busy_wait", busy, 1);
      wait_bytes(b0 + 3, 60, "t1");
      check("t1_busy_drop", busy, 0);
      check("t1_first_cyc", q_bcyc(b0), q_scyc(s0) + d + 1);
      check("t1_gap1", q_bcyc(b0 + 1) - q_bcyc(b0), 1);
      check("t1_gap2", q_bcyc(b0 + 2) - q_bcyc(b0), 2);
      check("t1_b0_const", q_byte(b0), 8'h54);
      check_frames(b0, e0, "t1");
      ticks(3);
      check("t1_one_start", start_sel.size(), s0 + 1);

      // 2: 'D' with a 10-cycle UART stall after the tag byte
      resp_delay[1] = $urandom_range(2, 15);
      fixed_val[1]  = 16'h0C8E;
      s0 = start_sel.size(); b0 = byte_q.size(); e0 = exp_q.size();
      send_cmd(C_D, c);
      wait_starts(s0 + 1, 20, "t2");
      check("t2_sel", q_sel(s0), pick(0, 1));
      check("t2_start_cyc", q_scyc(s0), c + 3);
      wait_bytes(b0 + 1, 60, "t2_tag");
      uart_ready = 1'b0;
      ticks(10);
      check("t2_stall_count", byte_q.size(), b0 + 1);
      check("t2_stall_valid", uart_tx_valid, 1);
      check("t2_stall_busy", busy, 1);
      uart_ready = 1'b1;
      wait_bytes(b0 + 3, 20, "t2");
      check_frames(b0, e0, "t2");
      wait_idle(10, "t2");

      // 3: reset, then 'T' and 'D' in consecutive cycles
      rst = 1'b1;
      ticks(2);
      rst   = 1'b0;
      mlast = 1;
      resp_delay[0] = $urandom_range(1, 15);
      resp_delay[1] = $urandom_range(1, 15);
      fixed_val[0]  = -1;
      fixed_val[1]  = -1;
      s0 = start_sel.size(); b0 = byte_q.size(); e0 = exp_q.size();
      send_cmd(C_T, c);
      send_cmd(C_D, c2);
      wait_starts(s0 + 2, 100, "t3");
      check("t3_sel0", q_sel(s0), pick(1, 0));
      check("t3_sel1", q_sel(s0 + 1), pick(0, 1));
      check("t3_start_cyc", q_scyc(s0), c + 3);
      wait_bytes(b0 + 6, 60, "t3");
      check_frames(b0, e0, "t3");
      wait_idle(10, "t3");
      ticks(5);
      check("t3_two_starts", start_sel.size(), s0 + 2);

      // 4: 'T' with no answer: timeout frame TIMEOUT cycles after the pulse
      resp_delay[0] = -1;
      s0 = start_sel.size(); b0 = byte_q.size(); e0 = exp_q.size();
      send_cmd(C_T, c);
      wait_starts(s0 + 1, 20, "t4");
      check("t4_sel", q_sel(s0), pick(1, 0));
      check("t4_start_cyc", q_scyc(s0), c + 3);
      wait_bytes(b0 + 3, TIMEOUT + 20, "t4");
      check("t4_first_cyc", q_bcyc(b0), q_scyc(s0) + TIMEOUT);
      check("t4_b0_const", q_byte(b0), 8'h45);
      check_frames(b0, e0, "t4");
      wait_idle(10, "t4");

      // 5: invalid byte, then auto-poll for two periods, then stop
      s0 = start_sel.size(); b0 = byte_q.size(); e0 = exp_q.size();
      send_cmd(8'h58, c);
      ticks(30);
      check("t5_inv_starts", start_sel.size(), s0);
      check("t5_inv_bytes", byte_q.size(), b0);
      check("t5_inv_busy", busy, 0);
      check("t5_inv_auto", auto_active, 0);
      resp_delay[0] = $urandom_range(1, 15);
      resp_delay[1] = $urandom_range(1, 15);
      send_cmd(C_A, c);
      check("t5_auto_on", auto_active, 1);
      wait_starts(s0 + 4, 3 * PERIOD, "t5");
      check("t5_sel0", q_sel(s0), pick(1, 1));
      check("t5_sel1", q_sel(s0 + 1), pick(1 - mlast == 0, 1 - mlast == 1));
      check("t5_sel2", q_sel(s0 + 2), pick(1, 1));
      check("t5_sel3", q_sel(s0 + 3), pick(1 - mlast == 0, 1 - mlast == 1));
      check("t5_tick1_cyc", q_scyc(s0), c + PERIOD + 3);
      check("t5_tick2_cyc", q_scyc(s0 + 2), c + 2 * PERIOD + 3);
      wait_idle(100, "t5_run");
      send_cmd(C_S, c);
      check("t5_auto_off", auto_active, 0);
      ticks(2 * PERIOD + 10);
      check("t5_stopped", start_sel.size(), s0 + 4);
      check_frames(b0, e0, "t5");

      // 6: reset while the high data byte is on the wire
      resp_delay[0] = $urandom_range(2, 15);
      s0 = start_sel.size(); b0 = byte_q.size();
      send_cmd(C_T, c);
      wait_bytes(b0 + 1, 60, "t6_tag");
      check("t6_valid_hi", uart_tx_valid, 1);
      rst = 1'b1;
      tick();
      check("t6_rst_valid", uart_tx_valid, 0);
      check("t6_rst_busy", busy, 0);
      rst   = 1'b0;
      mlast = 1;
      ticks(10);
      check("t6_no_more", byte_q.size(), b0 + 1);
      check("t6_tag_byte", q_byte(b0), 8'h54);
      resp_delay[0] = $urandom_range(1, 15);
      s0 = start_sel.size(); b0 = byte_q.size(); e0 = exp_q.size();
      send_cmd(C_T, c);
      wait_starts(s0 + 1, 20, "t6b");
      check("t6b_sel", q_sel(s0), pick(1, 0));
      check("t6b_start_cyc", q_scyc(s0), c + 3);
      wait_bytes(b0 + 3, 60, "t6b");
      check_frames(b0, e0, "t6b");
      wait_idle(10, "t6b");

      check("protocol", proto_err, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
